// File: rtl/sipo_frame_receiver.sv
// sipo_frame_receiver: start/data/even-parity/stop serial frame receiver with parallel word output
module sipo_frame_receiver #(
  parameter int WIDTH = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q;
  logic             p_q;
  // next shift-register value for the bit on the line, in the configured bit order
  always_comb sreg_d = LSB_FIRST ? {serial_in, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], serial_in};
  assign busy = state_q != IDLE;
  // frame FSM; pulses clear every clock, everything else advances only on bit strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      p_q        <= 1'b0;
      Q          <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (bit_en) begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (!serial_in) state_q <= DATA;
          end
          DATA: begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= PARITY;
          end
          PARITY: begin
            p_q     <= serial_in;
            state_q <= STOP;
          end
          default: begin
            if (serial_in) begin
              Q          <= sreg_q;
              parity_err <= ^sreg_q ^ p_q;
              valid      <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_q <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sipo_frame_receiver.sv
// tb_sipo_frame_receiver: scoreboard bench driving MSB-first and LSB-first receivers from one serial line
module tb_sipo_frame_receiver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_en = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] q_m, q_l;
  logic       v_m, v_l, pe_m, pe_l, fe_m, fe_l, b_m, b_l;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    logic       good;
    logic [7:0] q;
    logic       pe;
  } exp_t;
  exp_t       qm[$];
  exp_t       ql[$];
  logic [7:0] last_m = 8'h00, last_l = 8'h00;
  logic       last_pe = 1'b0;

  always #5 clk = ~clk;

  sipo_frame_receiver #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
    .Q(q_m), .valid(v_m), .parity_err(pe_m), .frame_err(fe_m), .busy(b_m)
  );
  sipo_frame_receiver #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
    .Q(q_l), .valid(v_l), .parity_err(pe_l), .frame_err(fe_l), .busy(b_l)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // monitor for the MSB-first receiver
  always @(negedge clk) begin
    if (!reset && (v_m || fe_m)) begin
      if (qm.size() == 0) check("msb_unexpected_pulse", {v_m, fe_m}, 2'b00);
      else begin
        exp_t e;
        e = qm.pop_front();
        check("msb_output", {v_m, fe_m, pe_m, q_m}, {e.good, !e.good, e.pe, e.q});
      end
    end
  end

  // monitor for the LSB-first receiver
  always @(negedge clk) begin
    if (!reset && (v_l || fe_l)) begin
      if (ql.size() == 0) check("lsb_unexpected_pulse", {v_l, fe_l}, 2'b00);
      else begin
        exp_t e;
        e = ql.pop_front();
        check("lsb_output", {v_l, fe_l, pe_l, q_l}, {e.good, !e.good, e.pe, e.q});
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      bit_en = 1'b0;
      serial_in = 1'($urandom);
    end
    @(negedge clk);
    bit_en = 1'b1;
    serial_in = b;
    @(posedge clk);
  endtask

  task automatic idle_bits(input int n, input int gap);
    repeat (n) send_bit(1'b1, gap);
  endtask

  // w is the transmitted order: w[7] goes first on the line
  task automatic send_frame(input logic [7:0] w, input logic pflip, input logic stop, input int gap);
    logic p;
    exp_t e;
    p = ($countones(w) % 2 == 1) ^ pflip;
    if (stop) begin
      last_m  = w;
      last_l  = rev8(w);
      last_pe = ($countones(w) + int'(p)) % 2 == 1;
    end
    e.good = stop; e.q = last_m; e.pe = last_pe; qm.push_back(e);
    e.q = last_l; ql.push_back(e);
    send_bit(1'b0, gap);
    #1 check("busy_after_start", {b_m, b_l}, 2'b11);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gap);
    send_bit(p, gap);
    send_bit(stop, gap);
    #1 check("pulse_after_stop", {b_m, v_m | fe_m}, 2'b01);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bit_en = 1'b1;
    serial_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bit_en = 1'b0;
    serial_in = 1'b1;
    last_m = 8'h00; last_l = 8'h00; last_pe = 1'b0;
    #1 check("reset_outputs", {q_m, v_m, pe_m, fe_m, b_m, q_l, v_l, pe_l, fe_l, b_l}, 26'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    do_reset();
    idle_bits(2, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    idle_bits(1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    do_reset();
    idle_bits(2, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    send_frame(8'h78, 1'b0, 1'b1, 0);
    #1 check("lsb_q_1e", q_l, 8'h1E);
    send_frame(8'hA5, 1'b0, 1'b1, 2);
    send_frame(8'h1E, 1'b0, 1'b1, 2);
    #1 check("msb_q_1e", q_m, 8'h1E);
    idle_bits(3, 2);
    for (int n = 0; n < 24; n++) begin
      int g;
      g = $urandom_range(2);
      send_frame(8'($urandom), $urandom_range(3) == 0, $urandom_range(4) != 0, g);
      idle_bits($urandom_range(2), g);
    end
    repeat (3) @(negedge clk);
    check("queues_drained", qm.size() + ql.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sipo_frame_receiver.md
# sipo_frame_receiver

- Serial-in/parallel-out frame receiver: the receiving end of the serial link driven by our universal shift register when it shifts a loaded word out.
- Detects a start bit, shifts in WIDTH data bits MSB- or LSB-first, checks an even-parity bit and a stop bit, then presents the word on a parallel output with a one-cycle valid strobe.
- Sits between the serial line and the parallel datapath.

## Interface
- WIDTH, 8, number of data bits per frame (2..32).
- LSB_FIRST, 0, 0: first data bit received is Q[WIDTH-1]; 1: first data bit received is Q[0].
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; serial_in is sampled only on edges where bit_en=1.
- serial_in  input  1  serial line; idles high.
- Q  output  WIDTH  last successfully received word.
- valid  output  1  one-cycle pulse: Q has just been updated.
- parity_err  output  1  parity result of the word currently on Q.
- frame_err  output  1  one-cycle pulse: stop bit was sampled low.
- busy  output  1  high in every state except IDLE.

## Operation
- Frame format, in order: start (0), WIDTH data bits, even-parity bit, stop (1).
- Even parity: the data bits plus the parity bit must contain an even number of ones.
- FSM states: IDLE, DATA, PARITY, STOP. No state changes on edges where bit_en=0; all registers hold.
- IDLE
  - serial_in=0 sampled: go to DATA, clear the bit counter.
  - serial_in=1 sampled: stay in IDLE.
  - No mid-bit start validation is performed.
- DATA
  - Each sampled bit shifts into an internal shift register.
  - LSB_FIRST=0: sreg <= {sreg[WIDTH-2:0], bit}.
  - LSB_FIRST=1: sreg <= {bit, sreg[WIDTH-1:1]}.
  - Counter increments per sampled bit. After the WIDTH-th bit go to PARITY; the counter is log2-sized and never wraps mid-frame.
- PARITY: capture the sampled bit into p; go to STOP.
- STOP, on the sampled bit:
  - serial_in=1: Q <= sreg, parity_err <= ^sreg ^ p, valid pulses.
  - serial_in=0: frame_err pulses; Q and parity_err hold; valid stays low.
  - Either case: go to IDLE.
- parity_err does not suppress valid; the word is delivered and flagged.
- A new start bit may be sampled on the very next bit_en after STOP. Back-to-back frames need no idle gap.

## Timing
- Reset values: Q=0, valid=0, parity_err=0, frame_err=0, busy=0; FSM in IDLE, sreg and counter 0.
- Reset has priority over bit_en. Reset asserted mid-frame discards the partial frame, with no valid or frame_err pulse. Reception resumes with the next start bit after reset deasserts.
- valid and frame_err are registered. Each is high for exactly the one clock cycle after the edge that sampled the stop bit, then low.
- Q and parity_err change on that same edge and are stable until the next good stop bit.
- busy goes high the cycle after the start-bit edge and low the cycle after the stop-bit edge.
- Latency with bit_en tied high: start bit sampled at edge 0, data at edges 1..WIDTH, parity at WIDTH+1, stop at WIDTH+2. valid is high during the cycle after edge WIDTH+2 (edge 10 for WIDTH=8).
- Gaps in bit_en only stretch the frame; the result is identical.

## Test plan
- Reset, then WIDTH=8, LSB_FIRST=0, bit_en=1: send 0, 1,0,1,0,0,1,0,1, 0, 1 -> Q=8'hA5, valid high one cycle after stop edge, parity_err=0, frame_err=0.
- Same frame with parity bit 1 -> Q=8'hA5, valid pulses, parity_err=1.
- Next frame 8'h3C with stop bit 0 -> frame_err one-cycle pulse, valid stays 0, Q holds previous value 8'hA5.
- Reset pulsed after 3 data bits of a frame -> all outputs 0, busy=0. Next full frame 8'hA5 is received correctly.
- LSB_FIRST=1 build: send 0, 0,1,1,1,1,0,0,0, 0, 1 -> Q=8'h1E, parity_err=0.
- bit_en high only every 3rd cycle, two back-to-back 8'hA5 and 8'h1E frames (MSB-first) with no idle bit between them -> two valid pulses, Q=8'hA5 then 8'h1E. serial_in toggling while bit_en=0 has no effect.
